aes_key_sched_ctrl: RTL

Control and streaming stage that sits directly upstream of the AES-128 key expansion block. It accepts a 128-bit cipher key through a valid/ready handshake and drives the expansion block's load/run code, round counter and key words. It then streams the 11 round keys (rounds 0..10) that come back from the expansion block to the round datapath through a second valid/ready handshake. When the downstream consumer stalls, the schedule freezes.

---
 rtl/aes_key_sched_ctrl_if.sv | 38 +++
 rtl/aes_key_sched_ctrl.sv | 101 ++++++++++
 2 files changed

// File: rtl/aes_key_sched_ctrl_if.sv
// Bus bundle between the key-schedule controller, its key source, the AES-128
// expansion block and the round-key consumer.
interface aes_key_sched_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                      key_valid_in;
    logic                      key_ready_out;
    logic [4*DATA_WIDTH-1:0]   key_in;
    logic [2:0]                FSM_core_out;
    logic [3:0]                core_count_out;
    logic [DATA_WIDTH-1:0]     data_out_0;
    logic [DATA_WIDTH-1:0]     data_out_1;
    logic [DATA_WIDTH-1:0]     data_out_2;
    logic [DATA_WIDTH-1:0]     data_out_3;
    logic [DATA_WIDTH-1:0]     ke_in_0;
    logic [DATA_WIDTH-1:0]     ke_in_1;
    logic [DATA_WIDTH-1:0]     ke_in_2;
    logic [DATA_WIDTH-1:0]     ke_in_3;
    logic                      rk_valid_out;
    logic                      rk_ready_in;
    logic [4*DATA_WIDTH-1:0]   rk_data_out;
    logic [3:0]                rk_index_out;
    logic                      done_out;

    modport master (
        input  key_valid_in, key_in, ke_in_0, ke_in_1, ke_in_2, ke_in_3, rk_ready_in,
        output key_ready_out, FSM_core_out, core_count_out,
        output data_out_0, data_out_1, data_out_2, data_out_3,
        output rk_valid_out, rk_data_out, rk_index_out, done_out
    );

    modport slave (
        output key_valid_in, key_in, ke_in_0, ke_in_1, ke_in_2, ke_in_3, rk_ready_in,
        input  key_ready_out, FSM_core_out, core_count_out,
        input  data_out_0, data_out_1, data_out_2, data_out_3,
        input  rk_valid_out, rk_data_out, rk_index_out, done_out
    );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// Accepts a cipher key, sequences the AES-128 expansion block and streams the
// round keys downstream; the schedule freezes while the consumer stalls.
module aes_key_sched_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_ROUNDS = 10
) (
    input logic                 clk,
    input logic                 rst,
    aes_key_sched_ctrl_if.master bus
);
    localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);

    localparam logic [2:0] CoreHold = 3'b000;
    localparam logic [2:0] CoreLoad = 3'b001;
    localparam logic [2:0] CoreRun  = 3'b010;

    typedef enum logic [1:0] {StIdle, StLoad, StRound} state_e;

    state_e                state_q, state_d;
    logic [3:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] data0_q, data0_d;
    logic [DATA_WIDTH-1:0] data1_q, data1_d;
    logic [DATA_WIDTH-1:0] data2_q, data2_d;
    logic [DATA_WIDTH-1:0] data3_q, data3_d;
    logic                  done_q, done_d;
    logic [2:0]            core_code;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        data0_d   = data0_q;
        data1_d   = data1_q;
        data2_d   = data2_q;
        data3_d   = data3_q;
        done_d    = 1'b0;
        core_code = CoreHold;
        unique case (state_q)
            StIdle: begin
                if (bus.key_valid_in) begin
                    data0_d = bus.key_in[4*DATA_WIDTH-1:3*DATA_WIDTH];
                    data1_d = bus.key_in[3*DATA_WIDTH-1:2*DATA_WIDTH];
                    data2_d = bus.key_in[2*DATA_WIDTH-1:DATA_WIDTH];
                    data3_d = bus.key_in[DATA_WIDTH-1:0];
                    count_d = 4'd0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                core_code = CoreLoad;
                count_d   = 4'd0;
                state_d   = StRound;
            end
            StRound: begin
                // Only advance the expansion registers on an actual handshake.
                if (bus.rk_ready_in) begin
                    core_code = CoreRun;
                    if (count_q == LastRound) begin
                        count_d = 4'd0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        count_d = count_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= 4'd0;
            data0_q <= '0;
            data1_q <= '0;
            data2_q <= '0;
            data3_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            data3_q <= data3_d;
            done_q  <= done_d;
        end
    end

    assign bus.key_ready_out  = (state_q == StIdle);
    assign bus.FSM_core_out   = core_code;
    assign bus.core_count_out = count_q;
    assign bus.data_out_0     = data0_q;
    assign bus.data_out_1     = data1_q;
    assign bus.data_out_2     = data2_q;
    assign bus.data_out_3     = data3_q;
    assign bus.rk_valid_out   = (state_q == StRound);
    assign bus.rk_data_out    = {bus.ke_in_0, bus.ke_in_1, bus.ke_in_2, bus.ke_in_3};
    assign bus.rk_index_out   = count_q;
    assign bus.done_out       = done_q;
endmodule
